// File: rtl/scan_mux_pkg.sv
// Shared definitions for the scanning channel multiplexer and its helpers.
// Latency: n/a (types, constants and elaboration-time functions only).
// Backpressure: n/a.
package scan_mux_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_MANUAL = 2'd1,
        ST_SCAN   = 2'd2
    } state_t;

    localparam logic MODE_MANUAL = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    // Ceiling log2, evaluated at elaboration to size counters.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) begin
            r++;
        end
        return r;
    endfunction

endpackage

// File: rtl/rate_divider.sv
// Down-counting rate divider: Tick is high while the count sits at zero.
// Latency: Tick follows the registered count; one Tick every DIV enabled cycles.
// Backpressure: none; Enable low freezes the count, Load restarts it at DIV-1.
module rate_divider
    import scan_mux_pkg::*;
#(
    parameter int DIV = 50000000
) (
    input  logic Clock,
    input  logic Resetn,
    input  logic Enable,
    input  logic Load,
    output logic Tick
);

    localparam int CW = (clog2(DIV) < 1) ? 1 : clog2(DIV);
    localparam logic [CW-1:0] RELOAD = CW'(DIV - 1);

    logic [CW-1:0] count;

    // Count down while enabled, reloading after zero; Load takes priority.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            count <= RELOAD;
        end else if (Load) begin
            count <= RELOAD;
        end else if (Enable) begin
            count <= (count == '0) ? RELOAD : count - CW'(1);
        end
    end

    // Tick is not gated by Enable so the consumer can use it without a loop.
    assign Tick = (count == '0);

endmodule

// File: rtl/scan_mux_reg.sv
// Registered N-channel W-bit mux with manual select or divider-paced auto-scan.
// Latency: 1 cycle from MuxSelect/Input/ChanMask to Out, CurChan, Valid, Wrap.
// Backpressure: none; Enable low holds outputs and freezes the scan divider.
module scan_mux_reg
    import scan_mux_pkg::*;
#(
    parameter int N   = 7,
    parameter int W   = 1,
    parameter int SW  = 3,
    parameter int DIV = 50000000
) (
    input  logic           Clock,
    input  logic           Resetn,
    input  logic [N*W-1:0] Input,
    input  logic [SW-1:0]  MuxSelect,
    input  logic           Mode,
    input  logic           Enable,
    input  logic [N-1:0]   ChanMask,
    output logic [W-1:0]   Out,
    output logic [SW-1:0]  CurChan,
    output logic           Valid,
    output logic           Wrap
);

    state_t         state, state_nxt;
    logic           paused, paused_nxt;   // idle because scan was disabled, resume without reload
    logic           scanning, entering;
    logic           tick, div_en;
    logic [SW:0]    thr;
    logic           hit_hi, hit_any, found;
    logic [SW-1:0]  idx_hi, idx_any, cand;
    logic [SW-1:0]  chan_nxt;
    logic [W-1:0]   out_nxt;
    logic           valid_nxt, wrap_nxt, pick;

    // Decide whether this cycle continues a scan or starts one, then find the
    // lowest eligible channel at or above the threshold, else the lowest overall.
    always_comb begin
        scanning = (state == ST_SCAN) || ((state == ST_IDLE) && paused);
        entering = Enable && (Mode == MODE_SCAN) && !scanning;
        thr      = entering ? {1'b0, MuxSelect} : ({1'b0, CurChan} + (SW+1)'(1));
        hit_hi   = 1'b0;
        hit_any  = 1'b0;
        idx_hi   = '0;
        idx_any  = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (ChanMask[k]) begin
                hit_any = 1'b1;
                idx_any = SW'(k);
                if ((SW+1)'(k) >= thr) begin
                    hit_hi = 1'b1;
                    idx_hi = SW'(k);
                end
            end
        end
        found = hit_any;
        cand  = hit_hi ? idx_hi : idx_any;
    end

    assign div_en = Enable && (Mode == MODE_SCAN) && scanning;

    rate_divider #(.DIV(DIV)) u_div (
        .Clock  (Clock),
        .Resetn (Resetn),
        .Enable (div_en),
        .Load   (entering),
        .Tick   (tick)
    );

    // Next state and next output values; a mode change always beats a divider step.
    always_comb begin
        state_nxt  = state;
        paused_nxt = paused;
        chan_nxt   = CurChan;
        out_nxt    = Out;
        valid_nxt  = Valid;
        wrap_nxt   = 1'b0;
        pick       = 1'b0;
        if (!Enable) begin
            state_nxt  = ST_IDLE;
            paused_nxt = scanning;
        end else if (Mode == MODE_MANUAL) begin
            state_nxt  = ST_MANUAL;
            paused_nxt = 1'b0;
            chan_nxt   = MuxSelect;
            pick       = 1'b1;
        end else begin
            state_nxt  = ST_SCAN;
            paused_nxt = 1'b0;
            pick       = 1'b1;
            if (entering) begin
                if (found) chan_nxt = cand;
            end else if (tick && found) begin
                chan_nxt = cand;
                wrap_nxt = (cand < CurChan);
            end
        end
        // Out shows the selected channel only when it is legal (and eligible in scan).
        if (pick) begin
            out_nxt   = '0;
            valid_nxt = 1'b0;
            for (int k = 0; k < N; k++) begin
                if ((chan_nxt == SW'(k)) && ((Mode == MODE_MANUAL) || ChanMask[k])) begin
                    out_nxt   = Input[k*W +: W];
                    valid_nxt = 1'b1;
                end
            end
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            state   <= ST_IDLE;
            paused  <= 1'b0;
            Out     <= '0;
            CurChan <= '0;
            Valid   <= 1'b0;
            Wrap    <= 1'b0;
        end else begin
            state   <= state_nxt;
            paused  <= paused_nxt;
            Out     <= out_nxt;
            CurChan <= chan_nxt;
            Valid   <= valid_nxt;
            Wrap    <= wrap_nxt;
        end
    end

endmodule

// File: tb/tb_scan_mux_reg.sv
// Self-checking bench for scan_mux_reg against a cycle-level behavioural model.
// Directed scenarios first, then randomized enable/mode/mask/select traffic.
module tb_scan_mux_reg;

    localparam int N   = 7;
    localparam int W   = 1;
    localparam int SW  = 3;
    localparam int DIV = 3;
    localparam int NW  = N * W;

    logic          clk = 1'b0;
    logic          rstn, en, mode;
    logic [NW-1:0] din;
    logic [SW-1:0] sel;
    logic [N-1:0]  mask;
    logic [W-1:0]  out;
    logic [SW-1:0] cur;
    logic          valid, wrap;

    int n_checks = 0;
    int n_fail   = 0;
    int wraps;
    int t1_exp [8] = '{1, 1, 0, 0, 1, 0, 1, 0};

    // Model: where the block is (0 idle, 1 manual, 2 scan), whether an idle
    // period interrupted a scan, and cycles elapsed since the last step.
    int m_out, m_cur, m_valid, m_wrap, m_elapsed, m_where;
    bit m_paused;

    always #5 clk = ~clk;

    scan_mux_reg #(.N(N), .W(W), .SW(SW), .DIV(DIV)) dut (
        .Clock     (clk),
        .Resetn    (rstn),
        .Input     (din),
        .MuxSelect (sel),
        .Mode      (mode),
        .Enable    (en),
        .ChanMask  (mask),
        .Out       (out),
        .CurChan   (cur),
        .Valid     (valid),
        .Wrap      (wrap)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int chan_data(input int k);
        return int'(din[k*W +: W]);
    endfunction

    // Circular search: first enabled channel starting at 'start' (0 if past the end).
    function automatic int find_from(input int start);
        int s;
        s = (start >= N) ? 0 : start;
        for (int i = 0; i < N; i++) begin
            if (mask[(s + i) % N]) return (s + i) % N;
        end
        return -1;
    endfunction

    task automatic model_edge();
        int nxt;
        if (!rstn) begin
            m_out = 0; m_cur = 0; m_valid = 0; m_wrap = 0;
            m_where = 0; m_paused = 0; m_elapsed = 0;
            return;
        end
        m_wrap = 0;
        if (!en) begin
            m_paused = (m_where == 2) || ((m_where == 0) && m_paused);
            m_where  = 0;
            return;
        end
        if (mode == 1'b0) begin
            m_where = 1; m_paused = 0; m_cur = int'(sel);
            if (m_cur < N) begin m_out = chan_data(m_cur); m_valid = 1; end
            else begin m_out = 0; m_valid = 0; end
            return;
        end
        if (m_where == 2 || m_paused) begin
            m_elapsed++;
            if (m_elapsed == DIV) begin
                m_elapsed = 0;
                nxt = find_from(m_cur + 1);
                if (nxt >= 0) begin
                    m_wrap = (nxt < m_cur) ? 1 : 0;
                    m_cur  = nxt;
                end
            end
        end else begin
            m_elapsed = 0;
            nxt = find_from(int'(sel));
            if (nxt >= 0) m_cur = nxt;
        end
        m_where = 2; m_paused = 0;
        if (m_cur < N && mask[m_cur]) begin m_valid = 1; m_out = chan_data(m_cur); end
        else begin m_valid = 0; m_out = 0; end
    endtask

    // Inputs are stable from here through the next rising edge; compare on the falling edge.
    task automatic step_check();
        model_edge();
        @(negedge clk);
        chk("out",   32'(out),   m_out);
        chk("cur",   32'(cur),   m_cur);
        chk("valid", 32'(valid), m_valid);
        chk("wrap",  32'(wrap),  m_wrap);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b0; en = 1'b0; mode = 1'b0;
        din = '0; sel = '0; mask = '0;
        m_where = 0; m_paused = 0; m_elapsed = 0;
        m_out = 0; m_cur = 0; m_valid = 0; m_wrap = 0;

        // Reset state
        step_check();
        step_check();

        // Manual sweep including the out-of-range select
        rstn = 1'b1; en = 1'b1; mode = 1'b0;
        din = NW'(7'b1010011); mask = '1;
        for (int i = 0; i < 8; i++) begin
            sel = SW'(i);
            step_check();
            chk("t1_out", 32'(out), t1_exp[i]);
            chk("t1_valid", 32'(valid), (i < 7) ? 1 : 0);
        end

        // Full scan over all channels: one wrap per lap
        sel = '0; mode = 1'b1; mask = 7'h7F;
        step_check();
        chk("t2_entry", 32'(cur), 0);
        wraps = 0;
        for (int i = 0; i < 7 * DIV; i++) begin
            step_check();
            wraps += int'(wrap);
        end
        chk("t2_wraps", wraps, 1);
        chk("t2_lap", 32'(cur), 0);

        // Sparse mask, entry searches upward from the select
        mode = 1'b0;
        step_check();
        mask = 7'b0100100; sel = 3'd3; mode = 1'b1;
        step_check();
        chk("t3_entry", 32'(cur), 5);
        for (int j = 1; j <= DIV; j++) step_check();
        chk("t3_cur2", 32'(cur), 2);
        chk("t3_wrap", 32'(wrap), 1);
        for (int j = 1; j <= DIV; j++) step_check();
        chk("t3_cur5", 32'(cur), 5);

        // Mask cleared, then a single channel restored
        mask = '0;
        step_check();
        chk("t4_valid0", 32'(valid), 0);
        chk("t4_out0", 32'(out), 0);
        mask = 7'h01;
        for (int j = 0; j <= DIV && !valid; j++) step_check();
        chk("t4_cur", 32'(cur), 0);
        chk("t4_valid1", 32'(valid), 1);

        // Reset in the middle of a scan, then re-entry
        mask = 7'h7F; mode = 1'b0; sel = 3'd4;
        step_check();
        mode = 1'b1;
        step_check();
        chk("t5_cur4", 32'(cur), 4);
        rstn = 1'b0;
        step_check();
        chk("t5_rst_out", 32'(out), 0);
        chk("t5_rst_cur", 32'(cur), 0);
        chk("t5_rst_valid", 32'(valid), 0);
        rstn = 1'b1;
        step_check();
        chk("t5_reentry", 32'(cur), 4);

        // Pause with one cycle left before expiry, then resume without reload
        step_check();
        en = 1'b0;
        for (int j = 0; j < 10; j++) step_check();
        chk("t6_frozen", 32'(cur), 4);
        en = 1'b1;
        step_check();
        chk("t6_hold", 32'(cur), 4);
        step_check();
        chk("t6_adv", 32'(cur), 5);

        // Randomized traffic
        for (int c = 0; c < 800; c++) begin
            rstn = ($urandom_range(99) != 0);
            en   = ($urandom_range(9) != 0);
            if ($urandom_range(19) == 0) mode = ~mode;
            if ($urandom_range(24) == 0) begin
                case ($urandom_range(3))
                    0:       mask = '0;
                    1:       mask = N'(1 << $urandom_range(N - 1));
                    default: mask = N'($urandom);
                endcase
            end
            sel = SW'($urandom);
            din = NW'($urandom);
            step_check();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
